// File: rtl/snake_head_stepper.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : snake_head_stepper
// Description : Owns the snake head coordinate and advances it one cell per
//               game tick. Supplies the per-axis 5-bit adder operands and
//               applies grid wrap or wall death to the sum. Also handles the
//               direction requests, the tick prescaler and run/idle/dead
//               control.
//               Optional feature macro: WALL_DEATH_EN (undefined = wrap mode).
// Revision    : 1.0 - initial release
// ============================================================================
module snake_head_stepper #(
    parameter int TICK_DIV = 16_000_000,
    parameter int GRID_W   = 32,
    parameter int GRID_H   = 32,
    parameter int START_X  = 16,
    parameter int START_Y  = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       pause,
    input  logic [3:0] dir_btn,
    output logic [4:0] head_x,
    output logic [4:0] head_y,
    output logic [1:0] dir,
    output logic       step,
    output logic       running,
    output logic       dead
);

    localparam int                 c_CNT_W    = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TICK_DIV - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_CNT_ZERO = '0;

    localparam logic [4:0] c_START_X = 5'(START_X);
    localparam logic [4:0] c_START_Y = 5'(START_Y);
    localparam logic [4:0] c_MAX_X   = 5'(GRID_W - 1);
    localparam logic [4:0] c_MAX_Y   = 5'(GRID_H - 1);
    localparam logic [4:0] c_PLUS1   = 5'b00001;
    localparam logic [4:0] c_MINUS1  = 5'b11111;

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_DEAD = 2'd2;

    localparam logic [1:0] c_UP    = 2'd0;
    localparam logic [1:0] c_RIGHT = 2'd1;
    localparam logic [1:0] c_DOWN  = 2'd2;
    localparam logic [1:0] c_LEFT  = 2'd3;

    logic [1:0]         r_state;
    logic [4:0]         r_headX;
    logic [4:0]         r_headY;
    logic [1:0]         r_dir;
    logic [1:0]         r_pending;
    logic [c_CNT_W-1:0] r_tickCnt;
    logic               r_step;
    logic               r_running;
    logic               r_dead;

    logic       w_reqValid;
    logic [1:0] w_req;
    logic       w_reqAccept;
    logic [4:0] w_deltaX;
    logic [4:0] w_deltaY;
    logic [4:0] w_sumX;
    logic [4:0] w_sumY;
    logic       w_moveX;
    logic       w_oob;
    logic [4:0] w_nextX;
    logic [4:0] w_nextY;
    logic       w_tickDue;

    // Reduce the button vector to one request (up > right > down > left) and reject reversals of the committed direction.
    always_comb begin
        w_reqValid = |dir_btn;
        w_req      = c_LEFT;
        if (dir_btn[3]) begin
            w_req = c_UP;
        end else if (dir_btn[2]) begin
            w_req = c_RIGHT;
        end else if (dir_btn[1]) begin
            w_req = c_DOWN;
        end
        w_reqAccept = w_reqValid && (w_req != (r_dir ^ 2'b10));
    end

    // Adder operands and sums; the move uses the pending direction, and range is judged on the pre-add coordinate.
    always_comb begin
        w_moveX  = (r_pending == c_RIGHT) || (r_pending == c_LEFT);
        w_deltaX = (r_pending == c_LEFT) ? c_MINUS1 : c_PLUS1;
        w_deltaY = (r_pending == c_UP)   ? c_MINUS1 : c_PLUS1;
        w_sumX   = r_headX + w_deltaX;
        w_sumY   = r_headY + w_deltaY;
        w_oob    = ((r_pending == c_RIGHT) && (r_headX == c_MAX_X)) ||
                   ((r_pending == c_LEFT)  && (r_headX == 5'd0))    ||
                   ((r_pending == c_DOWN)  && (r_headY == c_MAX_Y)) ||
                   ((r_pending == c_UP)    && (r_headY == 5'd0));
        w_nextX  = r_headX;
        w_nextY  = r_headY;
        if (w_moveX) begin
            if (w_oob) begin
                w_nextX = (r_pending == c_RIGHT) ? 5'd0 : c_MAX_X;
            end else begin
                w_nextX = w_sumX;
            end
        end else begin
            if (w_oob) begin
                w_nextY = (r_pending == c_DOWN) ? 5'd0 : c_MAX_Y;
            end else begin
                w_nextY = w_sumY;
            end
        end
        w_tickDue = (r_state == c_RUN) && !pause && (r_tickCnt == c_CNT_LAST);
    end

    // Control state, prescaler, direction registers and head position.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_IDLE;
            r_headX   <= c_START_X;
            r_headY   <= c_START_Y;
            r_dir     <= c_RIGHT;
            r_pending <= c_RIGHT;
            r_tickCnt <= c_CNT_ZERO;
            r_step    <= 1'b0;
            r_running <= 1'b0;
            r_dead    <= 1'b0;
        end else begin
            r_step <= 1'b0;
            if (((r_state == c_IDLE) || (r_state == c_DEAD)) && start) begin
                // A (re)start reloads everything; a request in the same cycle is overridden.
                r_state   <= c_RUN;
                r_headX   <= c_START_X;
                r_headY   <= c_START_Y;
                r_dir     <= c_RIGHT;
                r_pending <= c_RIGHT;
                r_tickCnt <= c_CNT_ZERO;
                r_running <= 1'b1;
                r_dead    <= 1'b0;
            end else begin
                if (w_reqAccept) begin
                    r_pending <= w_req;
                end
                if (w_tickDue) begin
                    r_tickCnt <= c_CNT_ZERO;
                    r_dir     <= r_pending;
`ifdef WALL_DEATH_EN
                    if (w_oob) begin
                        r_state   <= c_DEAD;
                        r_running <= 1'b0;
                        r_dead    <= 1'b1;
                    end else begin
                        r_headX <= w_nextX;
                        r_headY <= w_nextY;
                        r_step  <= 1'b1;
                    end
`else
                    r_headX <= w_nextX;
                    r_headY <= w_nextY;
                    r_step  <= 1'b1;
`endif
                end else if ((r_state == c_RUN) && !pause) begin
                    r_tickCnt <= r_tickCnt + c_CNT_ONE;
                end
            end
        end
    end

    assign head_x  = r_headX;
    assign head_y  = r_headY;
    assign dir     = r_dir;
    assign step    = r_step;
    assign running = r_running;
    assign dead    = r_dead;

endmodule
`default_nettype wire

// File: tb/tb_snake_head_stepper.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_snake_head_stepper
// Description : Bench for snake_head_stepper. Two instances (32x32 and 20x32
//               grids) share stimulus and are compared against a grid model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_snake_head_stepper;

    localparam int TD = 4;
`ifdef WALL_DEATH_EN
    localparam bit WALL = 1'b1;
`else
    localparam bit WALL = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       pause;
    logic [3:0] dir_btn;
    logic [4:0] hxA, hyA, hxB, hyB;
    logic [1:0] dA, dB;
    logic       sA, sB, rA, rB, kA, kB;

    int checks = 0;
    int errors = 0;

    // Reference model: coordinates as plain integers, index 0 = 32x32 grid, 1 = 20x32 grid.
    int gw [2] = '{32, 20};
    int gh [2] = '{32, 32};
    int mState [2];   // 0 idle, 1 run, 2 dead
    int mX [2], mY [2], mDir [2], mPend [2], mCnt [2], mStep [2];

    always #5 clk = ~clk;

    snake_head_stepper #(.TICK_DIV(TD), .GRID_W(32), .GRID_H(32), .START_X(16), .START_Y(16)) u_dutA (
        .clk(clk), .rst(rst), .start(start), .pause(pause), .dir_btn(dir_btn),
        .head_x(hxA), .head_y(hyA), .dir(dA), .step(sA), .running(rA), .dead(kA));

    snake_head_stepper #(.TICK_DIV(TD), .GRID_W(20), .GRID_H(32), .START_X(16), .START_Y(16)) u_dutB (
        .clk(clk), .rst(rst), .start(start), .pause(pause), .dir_btn(dir_btn),
        .head_x(hxB), .head_y(hyB), .dir(dB), .step(sB), .running(rB), .dead(kB));

    wire [14:0] gotA = {hxA, hyA, dA, sA, rA, kA};
    wire [14:0] gotB = {hxB, hyB, dB, sB, rB, kB};

    function automatic logic [14:0] expOf(input int k);
        logic [4:0] x, y;
        logic [1:0] d;
        x = 5'(mX[k]);
        y = 5'(mY[k]);
        d = 2'(mDir[k]);
        return {x, y, d, (mStep[k] != 0), (mState[k] == 1), (mState[k] == 2)};
    endfunction

    task automatic model_step();
        int req, dx, dy, nx, ny, oldPend;
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                mState[k] = 0; mX[k] = 16; mY[k] = 16; mDir[k] = 1; mPend[k] = 1; mCnt[k] = 0; mStep[k] = 0;
            end else begin
                req = -1;
                if (dir_btn[3]) req = 0;
                else if (dir_btn[2]) req = 1;
                else if (dir_btn[1]) req = 2;
                else if (dir_btn[0]) req = 3;
                mStep[k] = 0;
                if (mState[k] != 1 && start) begin
                    mState[k] = 1; mX[k] = 16; mY[k] = 16; mDir[k] = 1; mPend[k] = 1; mCnt[k] = 0;
                end else begin
                    oldPend = mPend[k];
                    if (req >= 0 && req != (mDir[k] + 2) % 4) mPend[k] = req;
                    if (mState[k] == 1 && !pause) begin
                        if (mCnt[k] == TD - 1) begin
                            mCnt[k] = 0;
                            mDir[k] = oldPend;
                            dx = (oldPend == 1) ? 1 : (oldPend == 3) ? -1 : 0;
                            dy = (oldPend == 2) ? 1 : (oldPend == 0) ? -1 : 0;
                            nx = mX[k] + dx;
                            ny = mY[k] + dy;
                            if (WALL && (nx < 0 || nx >= gw[k] || ny < 0 || ny >= gh[k])) begin
                                mState[k] = 2;
                            end else begin
                                mX[k] = (nx + gw[k]) % gw[k];
                                mY[k] = (ny + gh[k]) % gh[k];
                                mStep[k] = 1;
                            end
                        end else begin
                            mCnt[k] = mCnt[k] + 1;
                        end
                    end
                end
            end
        end
    endtask

    // One clock: edge, model update, settle; inputs are changed only after this returns.
    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
    endtask

    // Wait for a step pulse on instance A, at most 'limit' cycles.
    task automatic wait_step(input int limit, output bit ok, output int n);
        ok = 1'b0;
        n  = 0;
        while (!ok && n < limit) begin
            cyc();
            n++;
            if (sA) ok = 1'b1;
        end
    endtask

    task automatic restart();
        rst = 1'b1; start = 1'b0; pause = 1'b0; dir_btn = 4'b0000;
        cyc();
        rst = 1'b0; start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; pause = 1'b0; dir_btn = 4'b0100;
        cyc(); cyc();
        checks++;
        if (gotA !== {5'd16, 5'd16, 2'b01, 3'b000}) begin
            errors++; $display("FAIL reset_A got %h exp %h", gotA, {5'd16, 5'd16, 2'b01, 3'b000});
        end
        checks++;
        if (gotB !== expOf(1)) begin
            errors++; $display("FAIL reset_B got %h exp %h", gotB, expOf(1));
        end
        rst = 1'b0; start = 1'b0; dir_btn = 4'b0000;
    endtask

    task automatic test_start_steps();
        start = 1'b1;
        cyc();
        start = 1'b0;
        checks++;
        if (rA !== 1'b1 || hxA !== 5'd16 || dA !== 2'b01 || sA !== 1'b0) begin
            errors++; $display("FAIL start_run got run=%b x=%0d dir=%b step=%b exp run=1 x=16 dir=01 step=0", rA, hxA, dA, sA);
        end
        for (int i = 0; i < 12; i++) begin
            cyc();
            checks++;
            if (sA !== ((i % 4) == 3)) begin
                errors++; $display("FAIL step_timing cyc=%0d got %b exp %b", i, sA, ((i % 4) == 3));
            end
            if ((i % 4) == 3) begin
                checks++;
                if (hxA !== 5'(17 + i / 4) || hxB !== 5'(17 + i / 4)) begin
                    errors++; $display("FAIL step_headx got A=%0d B=%0d exp %0d", hxA, hxB, 17 + i / 4);
                end
            end
        end
    endtask

    // Rightward run across both grid edges (B wraps at 19, A at 31), compared to the model every cycle.
    task automatic test_wrap_right();
        for (int i = 0; i < 16 * TD; i++) begin
            cyc();
            checks++;
            if (gotA !== expOf(0) || gotB !== expOf(1)) begin
                errors++; $display("FAIL wrap_right cyc=%0d got A=%h B=%h exp A=%h B=%h", i, gotA, gotB, expOf(0), expOf(1));
            end
        end
    endtask

    // Up off row 0, then left off column 0.
    task automatic test_wrap_up_left();
        restart();
        dir_btn = 4'b1000;
        for (int i = 0; i < 17 * TD + 2; i++) begin
            cyc();
            dir_btn = 4'b0000;
            checks++;
            if (gotA !== expOf(0) || gotB !== expOf(1)) begin
                errors++; $display("FAIL wrap_up cyc=%0d got A=%h B=%h exp A=%h B=%h", i, gotA, gotB, expOf(0), expOf(1));
            end
        end
        dir_btn = 4'b0001;
        for (int i = 0; i < 17 * TD + 2; i++) begin
            cyc();
            dir_btn = 4'b0000;
            checks++;
            if (gotA !== expOf(0) || gotB !== expOf(1)) begin
                errors++; $display("FAIL wrap_left cyc=%0d got A=%h B=%h exp A=%h B=%h", i, gotA, gotB, expOf(0), expOf(1));
            end
        end
    endtask

    task automatic test_direction();
        bit ok;
        int n;
        restart();
        dir_btn = 4'b0001;
        cyc();
        dir_btn = 4'b0000;
        wait_step(2 * TD, ok, n);
        checks++;
        if (!ok || dA !== 2'b01 || hxA !== 5'd17) begin
            errors++; $display("FAIL reverse_reject got ok=%b dir=%b x=%0d exp ok=1 dir=01 x=17", ok, dA, hxA);
        end
        dir_btn = 4'b1000;
        cyc();
        dir_btn = 4'b0001;
        cyc();
        dir_btn = 4'b0000;
        wait_step(2 * TD, ok, n);
        checks++;
        if (!ok || dA !== 2'b00 || hyA !== 5'd15 || hxA !== 5'd17) begin
            errors++; $display("FAIL up_then_left got ok=%b dir=%b x=%0d y=%0d exp ok=1 dir=00 x=17 y=15", ok, dA, hxA, hyA);
        end
    endtask

    task automatic test_priority_pause();
        bit ok;
        int n;
        restart();
        dir_btn = 4'b1111;
        cyc();
        dir_btn = 4'b0000;
        wait_step(2 * TD, ok, n);
        checks++;
        if (!ok || dA !== 2'b00 || hyA !== 5'd15) begin
            errors++; $display("FAIL priority_up got ok=%b dir=%b y=%0d exp ok=1 dir=00 y=15", ok, dA, hyA);
        end
        cyc();
        pause = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cyc();
            checks++;
            if (sA !== 1'b0) begin
                errors++; $display("FAIL pause_nostep got %b exp 0", sA);
            end
        end
        pause = 1'b0;
        wait_step(3 * TD, ok, n);
        checks++;
        if (!ok || (n + 11) != TD + 10) begin
            errors++; $display("FAIL pause_delay got ok=%b gap=%0d exp gap=%0d", ok, n + 11, TD + 10);
        end
    endtask

    task automatic test_reset_on_step();
        int n;
        restart();
        cyc();
        n = 0;
        while (mCnt[0] != TD - 1 && n < 2 * TD) begin
            cyc();
            n++;
        end
        checks++;
        if (n >= 2 * TD) begin
            errors++; $display("FAIL rst_step_wait got timeout exp due step");
        end
        rst = 1'b1; start = 1'b1;
        cyc();
        rst = 1'b0; start = 1'b0;
        checks++;
        if (gotA !== {5'd16, 5'd16, 2'b01, 3'b000}) begin
            errors++; $display("FAIL rst_on_step got %h exp %h", gotA, {5'd16, 5'd16, 2'b01, 3'b000});
        end
        // Drive into the right wall, then request a restart.
        start = 1'b1;
        cyc();
        start = 1'b0;
        for (int i = 0; i < 17 * TD; i++) cyc();
        checks++;
        if (gotA !== expOf(0) || gotB !== expOf(1)) begin
            errors++; $display("FAIL wall_reach got A=%h B=%h exp A=%h B=%h", gotA, gotB, expOf(0), expOf(1));
        end
        start = 1'b1;
        cyc();
        start = 1'b0;
        checks++;
        if (gotA !== expOf(0) || gotB !== expOf(1) || rA !== 1'b1) begin
            errors++; $display("FAIL dead_restart got A=%h B=%h exp A=%h B=%h", gotA, gotB, expOf(0), expOf(1));
        end
    endtask

    task automatic test_random();
        rst = 1'b0;
        for (int i = 0; i < 600; i++) begin
            dir_btn = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
            pause   = ($urandom_range(0, 7) == 0);
            start   = ($urandom_range(0, 29) == 0);
            rst     = ($urandom_range(0, 149) == 0);
            cyc();
            checks++;
            if (gotA !== expOf(0) || gotB !== expOf(1)) begin
                errors++; $display("FAIL random cyc=%0d got A=%h B=%h exp A=%h B=%h", i, gotA, gotB, expOf(0), expOf(1));
            end
        end
        rst = 1'b0; start = 1'b0; pause = 1'b0; dir_btn = 4'b0000;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; pause = 1'b0; dir_btn = 4'b0000;
        test_reset();
        test_start_steps();
        test_wrap_right();
        test_wrap_up_left();
        test_direction();
        test_priority_pause();
        test_reset_on_step();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
